// File: rtl/ids_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ids_bus_pkg
// Description : Shared types and helpers for the IDS bus arbitration logic.
// Revision    : 1.0 - initial release
// ============================================================================
package ids_bus_pkg;

    // Arbiter top-level states
    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // RV data-memory port is always wired to master slot 0
    localparam int DMEM_MASTER_IDX = 0;

    // Index width that stays at least one bit wide for the single-master corner
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ids_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : ids_rr_pick
// Description : Combinational rotate-priority picker. Returns the first
//               requester (req & ~mask) found scanning upward from ptr,
//               wrapping modulo NUM_MASTERS.
// Revision    : 1.0 - initial release
// ============================================================================
module ids_rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [NUM_MASTERS-1:0] mask_i,
    input  logic [IDX_W-1:0]       ptr_i,
    output logic                   found_o,
    output logic [IDX_W-1:0]       winner_o
);

    logic [NUM_MASTERS-1:0] eligible;

    // Scan the eligible vector starting at ptr and keep the first hit
    always_comb begin
        int  j;
        logic hit;
        eligible = req_i & ~mask_i;
        hit      = 1'b0;
        winner_o = '0;
        j        = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_MASTERS) begin
                j = j - NUM_MASTERS;
            end
            if (!hit && eligible[j]) begin
                hit      = 1'b1;
                winner_o = IDX_W'(j);
            end
        end
        found_o = hit;
    end

endmodule
`default_nettype wire

// File: rtl/ids_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ids_rr_arbiter
// Description : N-master round-robin bus arbiter with owner lock and bounded
//               tenure under contention. All outputs are registered.
//               Optional macro IDS_ARB_DMEM_PRIO_EN gives master 0 (RV DMEM)
//               preemptive priority over non-locked owners.
// Revision    : 1.0 - initial release
// ============================================================================
module ids_rr_arbiter
    import ids_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 16,
    parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_MASTERS-1:0]        i_req,
    input  logic [NUM_MASTERS-1:0]        i_lock,
    output logic [NUM_MASTERS-1:0]        o_gnt,
    output logic [IDX_W-1:0]              o_gnt_id,
    output logic                          o_gnt_valid,
    output logic [$clog2(MAX_HOLD+1)-1:0] o_hold_cnt
);

    localparam int HOLD_W = $clog2(MAX_HOLD+1);

    arb_state_e             state_q;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic [IDX_W-1:0]       gnt_id_q;
    logic [HOLD_W-1:0]      hold_q;
    logic [IDX_W-1:0]       rr_ptr_q;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_winner;
    logic [IDX_W-1:0]       ptr_d;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic                   owner_req;
    logic                   owner_lock;
    logic                   hold_expired;
    logic                   rotate;
    logic                   prio_take;

    // The current owner is masked out so a handover never re-selects it;
    // in IDLE gnt_q is zero, giving a plain unmasked pick.
    ids_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .req_i    (i_req),
        .mask_i   (gnt_q),
        .ptr_i    (rr_ptr_q),
        .found_o  (pick_found),
        .winner_o (pick_winner)
    );

    // Owner status and handover decisions derived from the registered state
    always_comb begin
        owner_req    = i_req[gnt_id_q];
        owner_lock   = i_lock[gnt_id_q];
        hold_expired = !owner_lock && (hold_q >= HOLD_W'(MAX_HOLD-1));
        rotate       = (state_q == ARB_GRANT) && (!owner_req || hold_expired);
        win_onehot   = NUM_MASTERS'(1) << pick_winner;
        if (pick_winner == IDX_W'(NUM_MASTERS-1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = pick_winner + IDX_W'(1);
        end
`ifdef IDS_ARB_DMEM_PRIO_EN
        // Master 0 wins whenever it asks and the owner can be displaced;
        // a locked owner still holding its request is never preempted.
        prio_take = i_req[DMEM_MASTER_IDX]
                 && !((state_q == ARB_GRANT) && (gnt_id_q == IDX_W'(DMEM_MASTER_IDX)))
                 && ((state_q == ARB_IDLE) || !owner_req || hold_expired
                     || (!owner_lock && (hold_q != '0)));
`else
        prio_take = 1'b0;
`endif
    end

    // Arbitration FSM; every output is taken directly from these registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            hold_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (prio_take) begin
                        state_q  <= ARB_GRANT;
                        gnt_q    <= NUM_MASTERS'(1) << DMEM_MASTER_IDX;
                        gnt_id_q <= IDX_W'(DMEM_MASTER_IDX);
                        hold_q   <= '0;
                    end else if (pick_found) begin
                        state_q  <= ARB_GRANT;
                        gnt_q    <= win_onehot;
                        gnt_id_q <= pick_winner;
                        hold_q   <= '0;
                        rr_ptr_q <= ptr_d;
                    end
                end
                ARB_GRANT: begin
                    if (prio_take) begin
                        gnt_q    <= NUM_MASTERS'(1) << DMEM_MASTER_IDX;
                        gnt_id_q <= IDX_W'(DMEM_MASTER_IDX);
                        hold_q   <= '0;
                    end else if (rotate && pick_found) begin
                        gnt_q    <= win_onehot;
                        gnt_id_q <= pick_winner;
                        hold_q   <= '0;
                        rr_ptr_q <= ptr_d;
                    end else if (!owner_req) begin
                        state_q  <= ARB_IDLE;
                        gnt_q    <= '0;
                        gnt_id_q <= '0;
                        hold_q   <= '0;
                    end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
                        hold_q   <= hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_q  <= ARB_IDLE;
                    gnt_q    <= '0;
                    gnt_id_q <= '0;
                    hold_q   <= '0;
                end
            endcase
        end
    end

    assign o_gnt       = gnt_q;
    assign o_gnt_id    = gnt_id_q;
    assign o_gnt_valid = (state_q == ARB_GRANT);
    assign o_hold_cnt  = hold_q;

endmodule
`default_nettype wire

// File: tb/tb_ids_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ids_rr_arbiter
// Description : Self-checking bench for ids_rr_arbiter (NUM_MASTERS=4,
//               MAX_HOLD=16). Directed stimulus, a behavioural reference
//               model checked every cycle, and literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ids_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'h0;
    logic [3:0] lock  = 4'h0;
    logic [3:0] gnt;
    logic [1:0] gid;
    logic       gvalid;
    logic [4:0] hcnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: owner index (-1 when idle), tenure, rr pointer
    int m_owner = -1;
    int m_hold  = 0;
    int m_ptr   = 0;

    always #5 clk = ~clk;

    ids_rr_arbiter #(
        .NUM_MASTERS (N),
        .MAX_HOLD    (MH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_lock      (lock),
        .o_gnt       (gnt),
        .o_gnt_id    (gid),
        .o_gnt_valid (gvalid),
        .o_hold_cnt  (hcnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // First requester at or after ptr (wrapping), skipping master excl
    function automatic int pick(input logic [3:0] r, input int ptr, input int excl);
        int res;
        res = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (res < 0 && r[j] && j != excl) res = j;
        end
        return res;
    endfunction

    // Behavioural arbiter model advanced on each clock edge
    always @(posedge clk or negedge rst_n) begin : model
        int w;
        bit rel, tmo, unlocked, take0;
        if (!rst_n) begin
            m_owner = -1;
            m_hold  = 0;
            m_ptr   = 0;
        end else begin
            rel = 0; tmo = 0; unlocked = 0; take0 = 0;
            if (m_owner >= 0) begin
                unlocked = !lock[m_owner];
                rel      = !req[m_owner];
                tmo      = unlocked && (m_hold >= MH - 1);
            end
`ifdef IDS_ARB_DMEM_PRIO_EN
            take0 = req[0] && (m_owner != 0) &&
                    ((m_owner < 0) || rel || tmo || (unlocked && m_hold >= 1));
`endif
            w = pick(req, m_ptr, m_owner);
            if (take0) begin
                m_owner = 0;
                m_hold  = 0;
            end else if ((m_owner < 0 || rel || tmo) && w >= 0) begin
                m_owner = w;
                m_hold  = 0;
                m_ptr   = (w + 1) % N;
            end else if (m_owner >= 0 && rel) begin
                m_owner = -1;
                m_hold  = 0;
            end else if (m_owner >= 0 && m_hold < MH) begin
                m_hold++;
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-period
    always @(negedge clk) begin
        chk("model_gnt",   int'(gnt),    (m_owner < 0) ? 0 : (1 << m_owner));
        chk("model_id",    int'(gid),    (m_owner < 0) ? 0 : m_owner);
        chk("model_valid", int'(gvalid), (m_owner < 0) ? 0 : 1);
        chk("model_hold",  int'(hcnt),   m_hold);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with all masters requesting
        req = 4'b1111;
        repeat (3) tick();
        chk("rst_gnt",   int'(gnt),    0);
        chk("rst_valid", int'(gvalid), 0);
        chk("rst_hold",  int'(hcnt),   0);
        rst_n = 1'b1;
        tick();
        chk("first_gnt", int'(gnt), 1);
        chk("first_id",  int'(gid), 0);
`ifndef IDS_ARB_DMEM_PRIO_EN
        // Full contention: 0,1,2,3,0 each for exactly MH cycles
        for (int k = 1; k < 80; k++) begin
            tick();
            chk("rot_id",   int'(gid),  (k / 16) % 4);
            chk("rot_hold", int'(hcnt), k % 16);
            chk("rot_gnt",  int'(gnt),  1 << ((k / 16) % 4));
        end
`else
        repeat (79) tick();
`endif
        req = 4'b0000;
        tick();
        chk("idle_valid", int'(gvalid), 0);

        // Fresh reset so the pointer starts at 0 again
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Release handover with no idle bubble
        req = 4'b0110;
        repeat (3) begin
            tick();
            chk("rel_gnt1", int'(gnt), 4'b0010);
        end
        req = 4'b0100;
        tick();
        chk("rel_gnt2", int'(gnt), 4'b0100);
        req = 4'b0000;
        tick();
        chk("rel_idle", int'(gvalid), 0);

        // Locked owner keeps the bus under contention
        req = 4'b0100;
        tick();
        chk("lock_own", int'(gnt), 4'b0100);
        lock = 4'b0100;
        req  = 4'b1100;
        repeat (40) begin
            tick();
            chk("lock_gnt", int'(gnt), 4'b0100);
        end
        chk("lock_sat", int'(hcnt), 16);
        req  = 4'b1000;
        lock = 4'b0000;
        tick();
        chk("lock_hand", int'(gnt), 4'b1000);

        // Lone requester: no timeout
        repeat (50) begin
            tick();
            chk("solo_gnt", int'(gnt), 4'b1000);
        end
        chk("solo_sat", int'(hcnt), 16);
        req = 4'b0000;
        tick();
        chk("solo_idle", int'(gvalid), 0);
        chk("solo_gnt0", int'(gnt), 0);

        // Master 0 arrives while master 2 owns the bus
        req = 4'b0100;
        tick();
        chk("p_own", int'(gnt), 4'b0100);
        tick();
        req = 4'b0101;
        tick();
`ifdef IDS_ARB_DMEM_PRIO_EN
        chk("p_pre", int'(gnt), 4'b0001);
`else
        chk("p_wait", int'(gnt), 4'b0100);
`endif
        repeat (20) tick();
        chk("p_late", int'(gnt), 4'b0001);

        // Asynchronous reset mid-transfer drops the grant at once
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_gnt",   int'(gnt),    0);
        chk("arst_valid", int'(gvalid), 0);
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
